// File: rtl/mulcount_pkg.sv
// Shared definitions for the multiply-and-popcount coprocessor:
// register offsets, CTRL/STATUS bit positions, FSM states and popcount helper.
package mulcount_pkg;

  localparam logic [15:0] OFF_A1   = 16'h0000;
  localparam logic [15:0] OFF_A2   = 16'h0008;
  localparam logic [15:0] OFF_W    = 16'h0010;
  localparam logic [15:0] OFF_L    = 16'h0018;
  localparam logic [15:0] OFF_CTRL = 16'h0020;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQEN  = 2;

  localparam int ST_VALID  = 0;
  localparam int ST_READY  = 1;
  localparam int ST_BUSY   = 2;
  localparam int ST_ERR    = 3;
  localparam int ST_IRQ    = 4;
  localparam int ST_SIGNED = 5;
  localparam int ST_IRQEN  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/mulcount_seqmul.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, OP_WIDTH cycles.
// o_done is high during the cycle whose closing edge performs the final step.
module mulcount_seqmul #(
  parameter int OP_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [OP_WIDTH-1:0]   i_a,
  input  logic [OP_WIDTH-1:0]   i_b,
  output logic                  o_done,
  output logic [2*OP_WIDTH-1:0] o_prod
);

  localparam int P  = 2 * OP_WIDTH;
  localparam int CW = $clog2(OP_WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(OP_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [P-1:0]        r_mcand;
  logic [OP_WIDTH-1:0] r_mplier;
  logic [P-1:0]        r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{OP_WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_INIT;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_LAST;
      if (r_cnt == CNT_LAST) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CNT_LAST);
  assign o_prod = r_acc;

endmodule

// File: rtl/gpio_mulcount_engine.sv
// Bus-mapped multiply-and-popcount coprocessor with signed mode, busy/err
// tracking, level interrupt and a completed-operation counter on gpio_out.
//
// state   | meaning
// S_IDLE  | waiting for start; ready reflects last result
// S_MULT  | shift-add multiplier running (OP_WIDTH cycles)
// S_COUNT | sign fix-up, range check and popcount into staging regs
// S_DONE  | commit W/L/valid, bump counter, raise irq if enabled
module gpio_mulcount_engine
  import mulcount_pkg::*;
#(
  parameter int          OP_WIDTH  = 24,
  parameter int          RES_WIDTH = 32,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out,
  output logic        irq
);

  localparam int P = 2 * OP_WIDTH;
  localparam logic [15:0] ADDR_A1   = BASE_ADDR + OFF_A1;
  localparam logic [15:0] ADDR_A2   = BASE_ADDR + OFF_A2;
  localparam logic [15:0] ADDR_W    = BASE_ADDR + OFF_W;
  localparam logic [15:0] ADDR_L    = BASE_ADDR + OFF_L;
  localparam logic [15:0] ADDR_CTRL = BASE_ADDR + OFF_CTRL;

  state_t r_state, w_state_nxt;

  logic [OP_WIDTH-1:0]  r_a1, r_a2;
  logic [31:0]          r_w, r_w_nxt;
  logic [5:0]           r_l, r_l_nxt;
  logic                 r_valid, r_valid_nxt;
  logic                 r_ready, r_err, r_irq_pending;
  logic                 r_signed_mode, r_irq_en;
  logic                 r_op_signed, r_neg;
  logic [CNT_WIDTH-1:0] r_count;
  logic [31:0]          r_sdata_out;

  logic                 w_wr_a1, w_wr_a2, w_wr_ctrl, w_rd_status;
  logic                 w_busy, w_start_req, w_accept, w_sm_new;
  logic [OP_WIDTH-1:0]  w_mag_a, w_mag_b;
  logic                 w_mul_done;
  logic [P-1:0]         w_prod, w_res, w_ushift;
  logic signed [P-1:0]  w_sres, w_sext;
  logic                 w_fits;
  logic [31:0]          w_w32, w_status, w_rdata;

  assign w_wr_a1     = swr && (saddress == ADDR_A1);
  assign w_wr_a2     = swr && (saddress == ADDR_A2);
  assign w_wr_ctrl   = swr && (saddress == ADDR_CTRL);
  assign w_rd_status = srd && (saddress == ADDR_CTRL);
  assign w_busy      = (r_state != S_IDLE);
  assign w_start_req = w_wr_ctrl && sdata_in[CTRL_START];
  assign w_accept    = w_start_req && !w_busy;
  // The start write also carries the mode bit, so the snapshot uses it directly.
  assign w_sm_new    = sdata_in[CTRL_SIGNED];

  assign w_mag_a = (w_sm_new && r_a1[OP_WIDTH-1]) ? (~r_a1 + 1'b1) : r_a1;
  assign w_mag_b = (w_sm_new && r_a2[OP_WIDTH-1]) ? (~r_a2 + 1'b1) : r_a2;

  mulcount_seqmul #(.OP_WIDTH(OP_WIDTH)) u_seqmul (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept),
    .i_a     (w_mag_a),
    .i_b     (w_mag_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign w_res    = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_sres   = w_res;
  assign w_sext   = w_sres >>> (RES_WIDTH - 1);
  assign w_ushift = w_res >> RES_WIDTH;
  assign w_fits   = r_op_signed ? ((w_sext == '0) || (w_sext == '1)) : (w_ushift == '0);
  assign w_w32    = 32'(w_res[RES_WIDTH-1:0]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MULT;
      S_MULT:  if (w_mul_done) w_state_nxt = S_COUNT;
      S_COUNT: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a1          <= '0;
      r_a2          <= '0;
      r_w           <= '0;
      r_l           <= '0;
      r_valid       <= 1'b1;
      r_w_nxt       <= '0;
      r_l_nxt       <= '0;
      r_valid_nxt   <= 1'b1;
      r_ready       <= 1'b1;
      r_err         <= 1'b0;
      r_irq_pending <= 1'b0;
      r_signed_mode <= 1'b0;
      r_irq_en      <= 1'b0;
      r_op_signed   <= 1'b0;
      r_neg         <= 1'b0;
      r_count       <= '0;
    end else begin
      if (w_wr_a1) r_a1 <= sdata_in[OP_WIDTH-1:0];
      if (w_wr_a2) r_a2 <= sdata_in[OP_WIDTH-1:0];
      if (w_wr_ctrl) begin
        r_signed_mode <= sdata_in[CTRL_SIGNED];
        r_irq_en      <= sdata_in[CTRL_IRQEN];
      end
      if (w_accept) begin
        r_op_signed <= w_sm_new;
        r_neg       <= w_sm_new && (r_a1[OP_WIDTH-1] ^ r_a2[OP_WIDTH-1]);
        r_ready     <= 1'b0;
        r_valid     <= 1'b0;
      end
      // Later assignments win: a same-edge error or completion beats read-clear.
      if (w_rd_status) begin
        r_err         <= 1'b0;
        r_irq_pending <= 1'b0;
      end
      if (w_start_req && w_busy) r_err <= 1'b1;
      if (r_state == S_COUNT) begin
        r_w_nxt     <= w_w32;
        r_l_nxt     <= popcount32(w_w32);
        r_valid_nxt <= w_fits;
      end
      if (r_state == S_DONE) begin
        r_w     <= r_w_nxt;
        r_l     <= r_l_nxt;
        r_valid <= r_valid_nxt;
        r_ready <= 1'b1;
        r_count <= r_count + 1'b1;
        if (r_irq_en) r_irq_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[ST_VALID]  = r_valid;
    w_status[ST_READY]  = r_ready;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_ERR]    = r_err;
    w_status[ST_IRQ]    = r_irq_pending;
    w_status[ST_SIGNED] = r_signed_mode;
    w_status[ST_IRQEN]  = r_irq_en;
  end

  always_comb begin
    w_rdata = '0;
    case (saddress)
      ADDR_A1:   w_rdata = 32'(r_a1);
      ADDR_A2:   w_rdata = 32'(r_a2);
      ADDR_W:    w_rdata = r_w;
      ADDR_L:    w_rdata = 32'(r_l);
      ADDR_CTRL: w_rdata = w_status;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)    r_sdata_out <= '0;
    else if (srd) r_sdata_out <= w_rdata;
  end

  assign sdata_out = r_sdata_out;
  assign gpio_out  = 32'(r_count);
  assign irq       = r_irq_pending;

endmodule

// File: tb/tb_gpio_mulcount_engine.sv
// Directed bench for gpio_mulcount_engine with hand-computed expectations.
module tb_gpio_mulcount_engine;

  localparam logic [15:0] A_A1 = 16'h0380;
  localparam logic [15:0] A_A2 = 16'h0388;
  localparam logic [15:0] A_W  = 16'h0390;
  localparam logic [15:0] A_L  = 16'h0398;
  localparam logic [15:0] A_CT = 16'h03A0;
  localparam logic [15:0] A_UN = 16'h0384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  gpio_mulcount_engine dut (
    .clk       (clk),
    .reset     (reset),
    .saddress  (saddress),
    .srd       (srd),
    .swr       (swr),
    .sdata_in  (sdata_in),
    .sdata_out (sdata_out),
    .gpio_out  (gpio_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(negedge clk);
    swr = 1'b0;
  endtask

  task automatic rdreg(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    saddress = a; srd = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    d = sdata_out;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;
    rdreg(A_CT, rd); check("rst_status", rd, 32'h03);
    rdreg(A_W, rd);  check("rst_w", rd, 32'h0);
    rdreg(A_A1, rd); check("rst_a1", rd, 32'h0);

    // basic unsigned 3*5, also probes busy status one edge before commit
    wr(A_A1, 32'd3);
    wr(A_A2, 32'd5);
    rdreg(A_A2, rd); check("a2_readback", rd, 32'd5);
    wr(A_CT, 32'h1);
    cyc(24);
    rdreg(A_CT, rd); check("t1_busy_status", rd, 32'h04);
    cyc(1);
    rdreg(A_CT, rd); check("t1_status", rd, 32'h03);
    rdreg(A_W, rd);  check("t1_w", rd, 32'd15);
    rdreg(A_L, rd);  check("t1_l", rd, 32'd4);
    check("t1_gpio", gpio_out, 32'd1);
    rdreg(A_UN, rd); check("unmapped_read", rd, 32'h0);

    // unsigned overflow
    wr(A_A1, 32'h00FF_FFFF);
    wr(A_A2, 32'h00FF_FFFF);
    wr(A_CT, 32'h1);
    cyc(26);
    rdreg(A_CT, rd); check("t2_status", rd, 32'h02);
    rdreg(A_W, rd);  check("t2_w", rd, 32'hFE00_0001);
    rdreg(A_L, rd);  check("t2_l", rd, 32'd8);

    // signed -3 * 7
    wr(A_A1, 32'h00FF_FFFD);
    wr(A_A2, 32'd7);
    wr(A_CT, 32'h3);
    cyc(26);
    rdreg(A_CT, rd); check("t3_status", rd, 32'h23);
    rdreg(A_W, rd);  check("t3_w", rd, 32'hFFFF_FFEB);
    rdreg(A_L, rd);  check("t3_l", rd, 32'd30);
    check("t3_gpio", gpio_out, 32'd3);

    // start while busy: 4*6 must survive a second start and an A1 rewrite
    wr(A_A1, 32'd4);
    wr(A_A2, 32'd6);
    wr(A_CT, 32'h1);
    cyc(3);
    wr(A_A1, 32'd9);
    wr(A_CT, 32'h1);
    cyc(30);
    rdreg(A_W, rd);  check("t4_w", rd, 32'd24);
    check("t4_gpio", gpio_out, 32'd4);
    rdreg(A_CT, rd); check("t4_status_err", rd, 32'h0B);
    rdreg(A_CT, rd); check("t4_status_clr", rd, 32'h03);
    rdreg(A_A1, rd); check("t4_a1", rd, 32'd9);

    // reset mid-operation
    wr(A_A1, 32'd5);
    wr(A_A2, 32'd5);
    wr(A_CT, 32'h1);
    cyc(5);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("t5_gpio", gpio_out, 32'd0);
    rdreg(A_CT, rd); check("t5_status", rd, 32'h03);
    rdreg(A_W, rd);  check("t5_w", rd, 32'h0);
    cyc(30);
    check("t5_gpio_after", gpio_out, 32'd0);
    wr(A_A1, 32'd7);
    wr(A_A2, 32'd6);
    wr(A_CT, 32'h1);
    cyc(26);
    rdreg(A_W, rd);  check("t5_w2", rd, 32'd42);
    rdreg(A_L, rd);  check("t5_l2", rd, 32'd3);
    check("t5_gpio2", gpio_out, 32'd1);

    // interrupt, with exact commit-edge timing
    wr(A_A1, 32'd2);
    wr(A_A2, 32'd2);
    wr(A_CT, 32'h5);
    cyc(25);
    check("t6_irq_early", {31'd0, irq}, 32'h0);
    cyc(1);
    check("t6_irq_rise", {31'd0, irq}, 32'h1);
    cyc(3);
    check("t6_irq_hold", {31'd0, irq}, 32'h1);
    rdreg(A_CT, rd); check("t6_status", rd, 32'h53);
    check("t6_irq_clr", {31'd0, irq}, 32'h0);
    rdreg(A_W, rd);  check("t6_w", rd, 32'd4);
    check("t6_gpio", gpio_out, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_mulcount_engine.md
# gpio_mulcount_engine

Bus-mapped multiply-and-popcount coprocessor on the emulated GPIO peripheral bus; next generation of the existing 24×24 multiply unit. Operand width, result width, counter width and base address are parameters. Adds a signed mode, a sequential shift-add datapath with busy tracking, an error flag for start-while-busy, and a level interrupt. Sits behind the `saddress`/`srd`/`swr` slave port; `gpio_out` exposes the completed-operation count.

## Interface
- `OP_WIDTH`, 24: operand width in bits; must be ≤32.
- `RES_WIDTH`, 32: result width in bits; must satisfy RES_WIDTH ≤ 2·OP_WIDTH and RES_WIDTH ≤ 32.
- `CNT_WIDTH`, 16: operation counter width in bits; must be ≤32.
- `BASE_ADDR`, 16'h0380: address of A1. Other registers are at fixed offsets from it.

- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `saddress` in 16: register address. Decoded as a full 16-bit compare.
- `srd` in 1: read strobe, sampled on `clk`.
- `swr` in 1: write strobe, sampled on `clk`.
- `sdata_in` in 32: write data.
- `sdata_out` out 32: registered read data.
- `gpio_out` out 32: operation count, zero-extended.
- `irq` out 1: level interrupt, equal to `irq_pending`.

## Operation
- Register map (offsets from BASE_ADDR):
  - +0x00 A1: RW, low OP_WIDTH bits.
  - +0x08 A2: RW, low OP_WIDTH bits.
  - +0x10 W: RO, last completed result, zero-extended to 32 bits.
  - +0x18 L: RO, popcount of W.
  - +0x20 CTRL/STATUS.
- CTRL write bits:
  - b0 start.
  - b1 signed_mode, stored on every write.
  - b2 irq_en, stored on every write.
- STATUS read bits:
  - b0 valid: result fits in RES_WIDTH.
  - b1 ready.
  - b2 busy.
  - b3 err.
  - b4 irq_pending.
  - b5 signed_mode.
  - b6 irq_en.
  - Other bits read 0.
- Reading STATUS clears err and irq_pending.
- Unmapped reads return 0. Unmapped writes are ignored.
- Start accepted while idle:
  - Snapshot A1, A2 and signed_mode.
  - Clear ready and valid; set busy.
- Start while busy: ignored and sets err. The running operation is unaffected.
- A1/A2 writes during busy update the registers only; they do not affect the running operation.
- Unsigned mode:
  - Full product is 2·OP_WIDTH bits.
  - W = product[RES_WIDTH-1:0].
  - valid = 1 when all bits above RES_WIDTH are 0.
- Signed mode:
  - Operands are two's complement.
  - Multiply the magnitudes, then negate the product if the operand signs differ.
  - W = low RES_WIDTH bits.
  - valid = 1 when the product lies within signed RES_WIDTH range.
- L = number of ones in W[RES_WIDTH-1:0].
- Operation counter:
  - Increments on each completion.
  - Wraps from 2^CNT_WIDTH−1 to 0.
  - `gpio_out` = {0, count}.

## Timing
- FSM states:
  - IDLE → MULT on accepted start.
  - MULT → COUNT after OP_WIDTH cycles (one multiplier bit per cycle).
  - COUNT → DONE after 1 cycle; computes valid and L.
  - DONE → IDLE after 1 cycle.
- Updates in DONE:
  - W, L and valid are registered.
  - ready=1, busy=0, counter+1.
  - irq_pending=1 if irq_en.
- Latency: for a start on edge k, results and status are updated at edge k+OP_WIDTH+2.
- Reads: `sdata_out` is loaded on the edge where `srd`=1 and is stable until the next read.
- Simultaneous `srd` and `swr` are both serviced; the read returns the pre-edge value.
- STATUS read on the same edge as DONE:
  - Returns pre-edge values.
  - The set of irq_pending wins over the read-clear.
  - err is cleared.
- Start on the same edge as DONE: treated as busy, so it is ignored and sets err.
- Reset values:
  - `sdata_out` = 0.
  - `gpio_out` = 0.
  - `irq` = 0.
  - A1, A2, W, L = 0.
  - ready = 1, valid = 1.
  - busy, err, irq_pending, signed_mode, irq_en = 0.
  - Counter = 0.
  - FSM in IDLE.
- Reset mid-operation aborts the operation; no completion is counted.

## Structure
- Package `mulcount_pkg` holds:
  - Register offsets.
  - STATUS/CTRL bit indices.
  - FSM state enum (IDLE, MULT, COUNT, DONE).
- Sub-module `mulcount_seqmul`: OP_WIDTH-parametrised shift-add multiplier with start/done handshake, operating on unsigned magnitudes. Sign handling and popcount live in the top level.

## Test plan
- Basic unsigned multiply: A1=3, A2=5, start=0x1. After 26 cycles, STATUS=0x03, W=15, L=4, gpio_out=1.
- Unsigned overflow: A1=A2=0xFFFFFF, unsigned mode. W=0xFE000001, valid=0 (STATUS b0=0), L=8.
- Signed multiply: A1=0xFFFFFD (−3), A2=7, CTRL=0x3. W=0xFFFFFFEB, valid=1, L=30.
- Start while busy: second start 5 cycles after the first. STATUS err=1 and W equals the first result only; gpio_out rises by exactly 1; a second STATUS read shows err=0.
- Reset mid-operation: `reset` pulsed during MULT. Next cycle, busy=0, ready=1, gpio_out=0, W=0; a following start completes normally.
- Interrupt: CTRL=0x5 with A1=2, A2=2. `irq` rises at the DONE edge and stays high until STATUS is read, which returns b4=1; `irq` is 0 on the next cycle.
